// File: rtl/regfile_wb_scheduler_if.sv
// Writeback request bundle from the two sources (ALU = a, LSU = b) into the scheduler.
// Sources drive valid/rd/data and hold them until the scheduler returns ready.
interface regfile_wb_scheduler_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              a_valid;
    logic [ADDR_W-1:0] a_rd;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_rd;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;

    modport master (
        output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        input  a_ready, b_ready
    );

    modport slave (
        input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        output a_ready, b_ready
    );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Purpose: round-robin arbiter for the register file write port plus a RAW/WAW scoreboard.
// Latency: 1 cycle from writeback handshake to rf_we/rf_rd/rf_wdata.
// Backpressure: the losing source sees ready low and must hold its request; one grant per cycle.
module regfile_wb_scheduler #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 2 ** ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    regfile_wb_scheduler_if.slave wb,
    input  logic                iss_valid,
    input  logic [ADDR_W-1:0]   iss_rd,
    input  logic [ADDR_W-1:0]   q_rs1,
    input  logic [ADDR_W-1:0]   q_rs2,
    output logic                q_busy1,
    output logic                q_busy2,
    output logic                rf_we,
    output logic [ADDR_W-1:0]   rf_rd,
    output logic [DATA_W-1:0]   rf_wdata,
    output logic [NREG-1:0]     busy_vec,
    output logic                sb_err
);

    typedef enum logic {FAV_A = 1'b0, FAV_B = 1'b1} ptr_t;

    ptr_t              ptr_q, ptr_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_rd_q, rf_rd_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic              sb_err_q, sb_err_d;

    logic              grant_a, grant_b;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;
    logic              wr, iss_set;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q      <= FAV_A;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
            busy_q     <= '0;
            sb_err_q   <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
            sb_err_q   <= sb_err_d;
        end
    end

    always_comb begin
        grant_a  = wb.a_valid && (!wb.b_valid || (ptr_q == FAV_A));
        grant_b  = wb.b_valid && !grant_a;
        sel_rd   = grant_a ? wb.a_rd : wb.b_rd;
        sel_data = grant_a ? wb.a_data : wb.b_data;

        ptr_d = ptr_q;
        if (grant_a) begin
            ptr_d = FAV_B;
        end else if (grant_b) begin
            ptr_d = FAV_A;
        end

        // x0 handshakes complete but never reach the register file or scoreboard.
        wr         = (grant_a || grant_b) && (sel_rd != '0);
        rf_we_d    = wr;
        rf_rd_d    = wr ? sel_rd : rf_rd_q;
        rf_wdata_d = wr ? sel_data : rf_wdata_q;

        iss_set = iss_valid && (iss_rd != '0);

        // Set is applied after clear so a new producer wins over a retiring one.
        busy_d = busy_q;
        if (wr) begin
            busy_d[sel_rd] = 1'b0;
        end
        if (iss_set) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        sb_err_d = (iss_set && busy_q[iss_rd]) || (wr && !busy_q[sel_rd]);
    end

    assign wb.a_ready = grant_a;
    assign wb.b_ready = grant_b;
    assign q_busy1    = (q_rs1 != '0) && busy_q[q_rs1];
    assign q_busy2    = (q_rs2 != '0) && busy_q[q_rs2];
    assign rf_we      = rf_we_q;
    assign rf_rd      = rf_rd_q;
    assign rf_wdata   = rf_wdata_q;
    assign busy_vec   = busy_q;
    assign sb_err     = sb_err_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: arbitration, write port timing, scoreboard and errors.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1-2 units later.
module tb_regfile_wb_scheduler;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    logic              clk;
    logic              reset;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_rd;
    logic [ADDR_W-1:0] q_rs1;
    logic [ADDR_W-1:0] q_rs2;
    logic              q_busy1;
    logic              q_busy2;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_wdata;
    logic [NREG-1:0]   busy_vec;
    logic              sb_err;

    int checks = 0;
    int errors = 0;

    regfile_wb_scheduler_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wbif ();

    regfile_wb_scheduler #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) dut (
        .clk(clk), .reset(reset), .wb(wbif.slave),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .q_busy1(q_busy1), .q_busy2(q_busy2),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .busy_vec(busy_vec), .sb_err(sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wbif.a_valid = 1'b0; wbif.a_rd = '0; wbif.a_data = '0;
        wbif.b_valid = 1'b0; wbif.b_rd = '0; wbif.b_data = '0;
        iss_valid = 1'b0; iss_rd = '0;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    task automatic test_reset;
        idle();
        q_rs1 = '0; q_rs2 = '0;
        reset = 1'b0;
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", rf_we); end
        checks++; if (rf_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d exp 0", rf_rd); end
        checks++; if (rf_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", rf_wdata); end
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL reset_busy got %h exp 0", busy_vec); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", sb_err); end
        tick(); tick();
        reset = 1'b1;
        // Issue r6 and write r4 (not busy): next cycle rf_we=1, busy[6]=1, sb_err=1.
        iss_valid = 1'b1; iss_rd = 5'd6;
        wbif.a_valid = 1'b1; wbif.a_rd = 5'd4; wbif.a_data = 32'h1234_5678;
        tick();
        idle();
        checks++; if (rf_we !== 1'b1 || busy_vec !== 32'h40 || sb_err !== 1'b1) begin
            errors++; $display("FAIL pre_reset_state got we=%b busy=%h err=%b exp we=1 busy=00000040 err=1", rf_we, busy_vec, sb_err);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (rf_we !== 1'b0 || busy_vec !== 32'h0 || sb_err !== 1'b0) begin
            errors++; $display("FAIL async_reset got we=%b busy=%h err=%b exp we=0 busy=0 err=0", rf_we, busy_vec, sb_err);
        end
        tick();
        reset = 1'b1;
        wbif.a_valid = 1'b1; wbif.a_rd = 5'd1; wbif.a_data = 32'hAAAA_0001;
        wbif.b_valid = 1'b1; wbif.b_rd = 5'd2; wbif.b_data = 32'hBBBB_0002;
        #1;
        checks++; if (wbif.a_ready !== 1'b1 || wbif.b_ready !== 1'b0) begin
            errors++; $display("FAIL reset_tie_grant got a=%b b=%b exp a=1 b=0", wbif.a_ready, wbif.b_ready);
        end
        tick();
        idle();
        checks++; if (rf_rd !== 5'd1 || rf_wdata !== 32'hAAAA_0001) begin
            errors++; $display("FAIL reset_tie_write got rd=%0d data=%h exp rd=1 data=aaaa0001", rf_rd, rf_wdata);
        end
    endtask

    task automatic test_single;
        do_reset();
        iss_valid = 1'b1; iss_rd = 5'd5;
        tick();
        idle();
        wbif.a_valid = 1'b1; wbif.a_rd = 5'd5; wbif.a_data = 32'hDEADBEEF;
        #1;
        checks++; if (wbif.a_ready !== 1'b1 || wbif.b_ready !== 1'b0) begin
            errors++; $display("FAIL single_ready got a=%b b=%b exp a=1 b=0", wbif.a_ready, wbif.b_ready);
        end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL single_latency got we=%b exp 0", rf_we); end
        tick();
        idle();
        checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_write got we=%b rd=%0d data=%h exp we=1 rd=5 data=deadbeef", rf_we, rf_rd, rf_wdata);
        end
        checks++; if (busy_vec !== 32'h0 || sb_err !== 1'b0) begin
            errors++; $display("FAIL single_sb got busy=%h err=%b exp busy=0 err=0", busy_vec, sb_err);
        end
        tick();
        checks++; if (rf_we !== 1'b0 || rf_rd !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_hold got we=%b rd=%0d data=%h exp we=0 rd=5 data=deadbeef", rf_we, rf_rd, rf_wdata);
        end
    endtask

    task automatic test_back_to_back;
        logic [ADDR_W-1:0] a_rds  [4];
        logic [ADDR_W-1:0] b_rds  [4];
        logic [ADDR_W-1:0] exp_rd [4];
        logic [DATA_W-1:0] exp_dat[4];
        logic              exp_a  [4];
        // Loser holds its request: A 10,11,11,12 / B 20,20,21,21 -> grants A,B,A,B.
        a_rds  = '{5'd10, 5'd11, 5'd11, 5'd12};
        b_rds  = '{5'd20, 5'd20, 5'd21, 5'd21};
        exp_rd = '{5'd10, 5'd20, 5'd11, 5'd21};
        exp_dat = '{32'hA000_000A, 32'hB000_0014, 32'hA000_000B, 32'hB000_0015};
        exp_a  = '{1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wbif.a_valid = 1'b1; wbif.a_rd = a_rds[i]; wbif.a_data = 32'hA000_0000 | 32'(a_rds[i]);
            wbif.b_valid = 1'b1; wbif.b_rd = b_rds[i]; wbif.b_data = 32'hB000_0000 | 32'(b_rds[i]);
            #1;
            checks++; if (wbif.a_ready !== exp_a[i] || wbif.b_ready !== !exp_a[i]) begin
                errors++; $display("FAIL tie_grant[%0d] got a=%b b=%b exp a=%b b=%b", i, wbif.a_ready, wbif.b_ready, exp_a[i], !exp_a[i]);
            end
            tick();
            checks++; if (rf_we !== 1'b1 || rf_rd !== exp_rd[i] || rf_wdata !== exp_dat[i]) begin
                errors++; $display("FAIL tie_write[%0d] got we=%b rd=%0d data=%h exp we=1 rd=%0d data=%h", i, rf_we, rf_rd, rf_wdata, exp_rd[i], exp_dat[i]);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_scoreboard;
        do_reset();
        q_rs1 = 5'd7; q_rs2 = 5'd0;
        iss_valid = 1'b1; iss_rd = 5'd7;
        #1;
        checks++; if (q_busy1 !== 1'b0) begin errors++; $display("FAIL sb_no_bypass_set got %b exp 0", q_busy1); end
        tick();
        idle();
        checks++; if (q_busy1 !== 1'b1 || busy_vec !== 32'h80) begin
            errors++; $display("FAIL sb_set got busy1=%b vec=%h exp busy1=1 vec=00000080", q_busy1, busy_vec);
        end
        wbif.b_valid = 1'b1; wbif.b_rd = 5'd7; wbif.b_data = 32'h0000_0777;
        #1;
        checks++; if (wbif.b_ready !== 1'b1 || q_busy1 !== 1'b1) begin
            errors++; $display("FAIL sb_clear_same_cycle got ready=%b busy1=%b exp ready=1 busy1=1", wbif.b_ready, q_busy1);
        end
        tick();
        idle();
        checks++; if (q_busy1 !== 1'b0 || rf_rd !== 5'd7 || sb_err !== 1'b0) begin
            errors++; $display("FAIL sb_clear got busy1=%b rd=%0d err=%b exp busy1=0 rd=7 err=0", q_busy1, rf_rd, sb_err);
        end
        // Clear of a non-busy r7 (error) together with a new issue of r7: set wins.
        iss_valid = 1'b1; iss_rd = 5'd7;
        wbif.a_valid = 1'b1; wbif.a_rd = 5'd7; wbif.a_data = 32'h0000_0007;
        tick();
        idle();
        q_rs2 = 5'd7;
        #1;
        checks++; if (busy_vec !== 32'h80 || q_busy1 !== 1'b1 || q_busy2 !== 1'b1) begin
            errors++; $display("FAIL sb_set_wins got vec=%h busy1=%b busy2=%b exp vec=00000080 busy1=1 busy2=1", busy_vec, q_busy1, q_busy2);
        end
        checks++; if (rf_we !== 1'b1 || sb_err !== 1'b1) begin
            errors++; $display("FAIL sb_set_wins_err got we=%b err=%b exp we=1 err=1", rf_we, sb_err);
        end
        q_rs2 = 5'd0;
        #1;
        checks++; if (q_busy2 !== 1'b0) begin errors++; $display("FAIL sb_rs_zero got %b exp 0", q_busy2); end
    endtask

    task automatic test_x0;
        wbif.a_valid = 1'b1; wbif.a_rd = 5'd0; wbif.a_data = 32'h1;
        iss_valid = 1'b1; iss_rd = 5'd0;
        #1;
        checks++; if (wbif.a_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got %b exp 1", wbif.a_ready); end
        tick();
        idle();
        checks++; if (rf_we !== 1'b0 || rf_rd !== 5'd7 || busy_vec !== 32'h80 || sb_err !== 1'b0) begin
            errors++; $display("FAIL x0_write got we=%b rd=%0d vec=%h err=%b exp we=0 rd=7 vec=00000080 err=0", rf_we, rf_rd, busy_vec, sb_err);
        end
    endtask

    task automatic test_errors;
        do_reset();
        iss_valid = 1'b1; iss_rd = 5'd3;
        tick();
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL err_first_issue got %b exp 0", sb_err); end
        tick();
        idle();
        checks++; if (sb_err !== 1'b1 || busy_vec !== 32'h8) begin
            errors++; $display("FAIL err_waw got err=%b vec=%h exp err=1 vec=00000008", sb_err, busy_vec);
        end
        tick();
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL err_waw_pulse got %b exp 0", sb_err); end
        wbif.b_valid = 1'b1; wbif.b_rd = 5'd9; wbif.b_data = 32'h9999_0009;
        tick();
        idle();
        checks++; if (sb_err !== 1'b1 || rf_we !== 1'b1 || rf_rd !== 5'd9 || rf_wdata !== 32'h9999_0009) begin
            errors++; $display("FAIL err_clear_idle got err=%b we=%b rd=%0d data=%h exp err=1 we=1 rd=9 data=99990009", sb_err, rf_we, rf_rd, rf_wdata);
        end
        checks++; if (busy_vec !== 32'h8) begin errors++; $display("FAIL err_clear_noop got %h exp 00000008", busy_vec); end
        tick();
        checks++; if (sb_err !== 1'b0 || rf_we !== 1'b0) begin
            errors++; $display("FAIL err_clear_pulse got err=%b we=%b exp err=0 we=0", sb_err, rf_we);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_scoreboard();
        test_x0();
        test_errors();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
